// File: rtl/cp0_pkg.sv
// Shared CP0 interrupt-controller definitions: sequencer states, the cause
// register location and the bit offset of the per-source cause flags.
package cp0_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SAVE,
        ST_CAUSE,
        ST_JUMP,
        ST_HANDLER,
        ST_RETURN
    } cp0_state_e;

    localparam int          NUM_SRC       = 3;
    localparam logic [4:0]  CAUSE_ADDR    = 5'd13;
    localparam logic [2:0]  CAUSE_SEL     = 3'd0;
    localparam int          CAUSE_BIT_OFS = 8;
    localparam logic [1:0]  SRC_NONE      = 2'd3;

endpackage

// File: rtl/cp0_prio_enc.sv
// Fixed-priority encoder: the lowest set request bit wins.
module cp0_prio_enc (
    input  logic [2:0] req_i,
    output logic [1:0] idx_o,
    output logic       valid_o
);

    always_comb begin
        idx_o = 2'd3;
        if (req_i[2]) idx_o = 2'd2;
        if (req_i[1]) idx_o = 2'd1;
        if (req_i[0]) idx_o = 2'd0;
    end

    assign valid_o = |req_i;

endmodule

// File: rtl/cp0_int_ctrl.sv
// CP0 interrupt sequencer: latches requests, saves EPC, writes the cause
// register, redirects to the per-source vector and handles the return.
module cp0_int_ctrl
    import cp0_pkg::*;
#(
    parameter logic [31:0] VEC_BASE   = 32'h0000_0800,
    parameter logic [31:0] VEC_STRIDE = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [2:0]  irq,
    input  logic [2:0]  mask,
    input  logic        ie,
    input  logic [31:0] pc_next,
    input  logic        eret,
    input  logic [31:0] epc_rd,
    output logic        epc_we,
    output logic [31:0] epc_din,
    output logic        cp0_we,
    output logic [4:0]  cp0_waddr,
    output logic [2:0]  cp0_sel,
    output logic [31:0] cp0_din,
    output logic        take_int,
    output logic [31:0] vector,
    output logic        ret_valid,
    output logic [31:0] ret_pc,
    output logic        in_handler,
    output logic [2:0]  pending,
    output logic [1:0]  cur_src
);

    cp0_state_e  state_q, state_d;
    logic [1:0]  src_q, src_d;
    logic [2:0]  pend_q, pend_d;
    logic [2:0]  clr_bits;
    logic [1:0]  hit_idx;
    logic        hit_vld;

    cp0_prio_enc u_prio (
        .req_i   (pend_q & mask),
        .idx_o   (hit_idx),
        .valid_o (hit_vld)
    );

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= ST_IDLE;
            src_q   <= SRC_NONE;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            pend_q  <= pend_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        src_d    = src_q;
        clr_bits = '0;
        case (state_q)
            ST_IDLE: if (ie && hit_vld) begin
                state_d  = ST_SAVE;
                src_d    = hit_idx;
                clr_bits = 3'b001 << hit_idx;
            end
            ST_SAVE:    state_d = ST_CAUSE;
            ST_CAUSE:   state_d = ST_JUMP;
            ST_JUMP:    state_d = ST_HANDLER;
            ST_HANDLER: if (eret) state_d = ST_RETURN;
            ST_RETURN: begin
                state_d = ST_IDLE;
                src_d   = SRC_NONE;
            end
            default:    state_d = ST_IDLE;
        endcase
        // A new request on the same edge as the service clear keeps its bit.
        pend_d = (pend_q & ~clr_bits) | irq;
    end

    always_comb begin
        epc_we     = 1'b0;
        epc_din    = '0;
        cp0_we     = 1'b0;
        cp0_waddr  = '0;
        cp0_sel    = '0;
        cp0_din    = '0;
        take_int   = 1'b0;
        vector     = '0;
        ret_valid  = 1'b0;
        ret_pc     = '0;
        in_handler = 1'b0;
        case (state_q)
            ST_SAVE: begin
                epc_we  = 1'b1;
                epc_din = pc_next;
            end
            ST_CAUSE: begin
                cp0_we    = 1'b1;
                cp0_waddr = CAUSE_ADDR;
                cp0_sel   = CAUSE_SEL;
                cp0_din   = 32'd1 << (CAUSE_BIT_OFS + int'(src_q));
            end
            ST_JUMP: begin
                take_int = 1'b1;
                vector   = VEC_BASE + {30'd0, src_q} * VEC_STRIDE;
            end
            ST_HANDLER: in_handler = 1'b1;
            ST_RETURN: begin
                ret_valid = 1'b1;
                ret_pc    = epc_rd;
            end
            default: ;
        endcase
    end

    assign pending = pend_q;
    assign cur_src = src_q;

endmodule

// File: tb/tb_cp0_int_ctrl.sv
// Bench for cp0_int_ctrl: directed vector table, a clear-mid-sequence case,
// then randomized traffic against a cycles-since-dispatch reference model.
module tb_cp0_int_ctrl;

    logic        clk = 1'b0;
    logic        clr;
    logic [2:0]  irq, mask;
    logic        ie, eret;
    logic [31:0] pc_next, epc_rd;
    logic        epc_we, cp0_we, take_int, ret_valid, in_handler;
    logic [31:0] epc_din, cp0_din, vector, ret_pc;
    logic [4:0]  cp0_waddr;
    logic [2:0]  cp0_sel, pending;
    logic [1:0]  cur_src;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    cp0_int_ctrl dut (
        .clk(clk), .clr(clr), .irq(irq), .mask(mask), .ie(ie),
        .pc_next(pc_next), .eret(eret), .epc_rd(epc_rd),
        .epc_we(epc_we), .epc_din(epc_din),
        .cp0_we(cp0_we), .cp0_waddr(cp0_waddr), .cp0_sel(cp0_sel), .cp0_din(cp0_din),
        .take_int(take_int), .vector(vector),
        .ret_valid(ret_valid), .ret_pc(ret_pc),
        .in_handler(in_handler), .pending(pending), .cur_src(cur_src)
    );

    typedef struct {
        logic [2:0]  irq;
        logic [2:0]  mask;
        logic        ie;
        logic        eret;
        logic [4:0]  str;   // {epc_we, cp0_we, take_int, ret_valid, in_handler}
        logic [2:0]  pend;
        logic [1:0]  src;
        logic [31:0] data;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [2:0] i, input logic [2:0] m, input logic e, input logic r,
                       input logic [4:0] s, input logic [2:0] p, input logic [1:0] c,
                       input logic [31:0] d);
        vec_t v;
        v.irq = i; v.mask = m; v.ie = e; v.eret = r;
        v.str = s; v.pend = p; v.src = c; v.data = d;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Data outputs are zero when inactive, so their OR isolates the live one.
    task automatic chk_all(input string tag, input logic [4:0] s, input logic [2:0] p,
                           input logic [1:0] c, input logic [31:0] d);
        chk({tag, " strobes"}, {27'd0, epc_we, cp0_we, take_int, ret_valid, in_handler}, {27'd0, s});
        chk({tag, " pending"}, {29'd0, pending}, {29'd0, p});
        chk({tag, " cur_src"}, {30'd0, cur_src}, {30'd0, c});
        chk({tag, " data"}, epc_din | cp0_din | vector | ret_pc, d);
        chk({tag, " waddr/sel"}, {24'd0, cp0_waddr, cp0_sel}, s[3] ? {24'd0, 5'd13, 3'd0} : 32'd0);
    endtask

    // Reference model: cycles since dispatch (0 = idle, 1..3 = save/cause/jump,
    // 4 = waiting in handler, 5 = returning) plus the pending set.
    int         m_cyc;
    int         m_src;
    logic [2:0] m_pend;

    task automatic model_edge();
        if (m_cyc == 0) begin
            if (ie && (m_pend & mask) != 0) begin
                for (int i = 2; i >= 0; i--) if (m_pend[i] && mask[i]) m_src = i;
                m_pend[m_src] = 1'b0;
                m_cyc = 1;
            end
        end else if (m_cyc < 4) m_cyc++;
        else if (m_cyc == 4) begin
            if (eret) m_cyc = 5;
        end else begin
            m_cyc = 0;
            m_src = 3;
        end
        m_pend = m_pend | irq;
    endtask

    task automatic model_check(input string tag);
        logic [4:0]  s;
        logic [31:0] d;
        s = 5'd0;
        d = 32'd0;
        case (m_cyc)
            1: begin s = 5'b10000; d = pc_next; end
            2: begin s = 5'b01000; d = 32'd1 << (8 + m_src); end
            3: begin s = 5'b00100; d = 32'h800 + 32'(m_src) * 32'h100; end
            4: s = 5'b00001;
            5: begin s = 5'b00010; d = epc_rd; end
            default: ;
        endcase
        chk_all(tag, s, m_pend, 2'(m_src), d);
    endtask

    initial begin
        clr = 1'b1; irq = '0; mask = '0; ie = 1'b0; eret = 1'b0;
        pc_next = 32'h100; epc_rd = 32'h2040;
        #12;
        chk_all("reset", 5'd0, 3'd0, 2'd3, 32'd0);
        @(posedge clk); #1 clr = 1'b0;

        // irq0 service, return with EPC 0x2040
        add(3'b001, 3'b111, 1, 0, 5'b00000, 3'b001, 3, 32'h0);
        add(3'b000, 3'b111, 1, 0, 5'b10000, 3'b000, 0, 32'h100);
        add(3'b000, 3'b111, 1, 0, 5'b01000, 3'b000, 0, 32'h100);
        add(3'b000, 3'b111, 1, 0, 5'b00100, 3'b000, 0, 32'h800);
        add(3'b000, 3'b111, 1, 0, 5'b00001, 3'b000, 0, 32'h0);
        add(3'b000, 3'b111, 1, 1, 5'b00010, 3'b000, 0, 32'h2040);
        add(3'b000, 3'b111, 1, 0, 5'b00000, 3'b000, 3, 32'h0);
        // simultaneous irq1/irq2: src1 first, src2 after eret
        add(3'b110, 3'b111, 1, 0, 5'b00000, 3'b110, 3, 32'h0);
        add(3'b000, 3'b111, 1, 0, 5'b10000, 3'b100, 1, 32'h100);
        add(3'b000, 3'b111, 1, 0, 5'b01000, 3'b100, 1, 32'h200);
        add(3'b000, 3'b111, 1, 0, 5'b00100, 3'b100, 1, 32'h900);
        add(3'b000, 3'b111, 1, 0, 5'b00001, 3'b100, 1, 32'h0);
        add(3'b000, 3'b111, 1, 1, 5'b00010, 3'b100, 1, 32'h2040);
        add(3'b000, 3'b111, 1, 0, 5'b00000, 3'b100, 3, 32'h0);
        add(3'b000, 3'b111, 1, 0, 5'b10000, 3'b000, 2, 32'h100);
        add(3'b000, 3'b111, 1, 0, 5'b01000, 3'b000, 2, 32'h400);
        add(3'b000, 3'b111, 1, 0, 5'b00100, 3'b000, 2, 32'hA00);
        add(3'b000, 3'b111, 1, 0, 5'b00001, 3'b000, 2, 32'h0);
        add(3'b000, 3'b111, 1, 1, 5'b00010, 3'b000, 2, 32'h2040);
        add(3'b000, 3'b111, 1, 0, 5'b00000, 3'b000, 3, 32'h0);
        // masked request retained, serviced once unmasked
        add(3'b010, 3'b000, 1, 0, 5'b00000, 3'b010, 3, 32'h0);
        add(3'b000, 3'b000, 1, 0, 5'b00000, 3'b010, 3, 32'h0);
        add(3'b000, 3'b010, 1, 0, 5'b10000, 3'b000, 1, 32'h100);
        add(3'b000, 3'b010, 1, 0, 5'b01000, 3'b000, 1, 32'h200);
        add(3'b000, 3'b010, 1, 0, 5'b00100, 3'b000, 1, 32'h900);
        add(3'b000, 3'b010, 1, 0, 5'b00001, 3'b000, 1, 32'h0);
        add(3'b000, 3'b010, 1, 1, 5'b00010, 3'b000, 1, 32'h2040);
        add(3'b000, 3'b010, 1, 0, 5'b00000, 3'b000, 3, 32'h0);
        // eret in idle ignored; ie=0 holds the request
        add(3'b000, 3'b111, 1, 1, 5'b00000, 3'b000, 3, 32'h0);
        add(3'b001, 3'b111, 0, 0, 5'b00000, 3'b001, 3, 32'h0);
        add(3'b000, 3'b111, 0, 0, 5'b00000, 3'b001, 3, 32'h0);
        add(3'b000, 3'b111, 1, 0, 5'b10000, 3'b000, 0, 32'h100);

        foreach (tbl[k]) begin
            irq = tbl[k].irq; mask = tbl[k].mask; ie = tbl[k].ie; eret = tbl[k].eret;
            @(posedge clk); #1;
            chk_all($sformatf("vec%0d", k), tbl[k].str, tbl[k].pend, tbl[k].src, tbl[k].data);
        end

        // clr during CAUSE aborts the sequence at once
        irq = '0; eret = 1'b0;
        @(posedge clk); #1;
        chk("pre-clr cp0_we", {31'd0, cp0_we}, 32'd1);
        #2 clr = 1'b1;
        #1 chk_all("clr in CAUSE", 5'd0, 3'd0, 2'd3, 32'd0);
        @(posedge clk); #1 clr = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            chk_all("post-clr", 5'd0, 3'd0, 2'd3, 32'd0);
        end

        // randomized traffic against the model
        m_cyc = 0; m_src = 3; m_pend = '0;
        for (int n = 0; n < 3000; n++) begin
            irq     = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            mask    = 3'($urandom_range(0, 7));
            ie      = ($urandom_range(0, 7) != 0);
            eret    = ($urandom_range(0, 3) == 0);
            pc_next = $urandom;
            epc_rd  = $urandom;
            model_edge();
            @(posedge clk); #1;
            model_check("rand");
            if ($urandom_range(0, 149) == 0) begin
                #2 clr = 1'b1;
                #1 chk_all("rand clr", 5'd0, 3'd0, 2'd3, 32'd0);
                @(posedge clk); #1 clr = 1'b0;
                m_cyc = 0; m_src = 3; m_pend = '0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
